// File: rtl/cdb_arbiter_if.sv
// Write-back packet type and the FU-result / CDB bundle shared by execute, arbiter and consumers.
// Combinational grants in the same cycle as the request; CDB ports are registered.
// No backpressure from the CDB side; FUs hold their packet until granted.

package cdb_arbiter_pkg;

  typedef struct packed {
    logic        is_valid;
    logic [5:0]  rob_tag;
    logic [6:0]  prf_dst;
    logic [31:0] data;
    logic        exc;
  } writeback_packet_t;

endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU  = 5,
  parameter int NUM_CDB = 2
);
  import cdb_arbiter_pkg::*;

  writeback_packet_t [NUM_FU-1:0]  fu_results;
  logic              [NUM_FU-1:0]  fu_cdb_gnts;
  writeback_packet_t [NUM_CDB-1:0] cdb_ports;

  // execute side: presents results, sees grants and the broadcast
  modport master (
    output fu_results,
    input  fu_cdb_gnts,
    input  cdb_ports
  );

  // arbiter side
  modport slave (
    input  fu_results,
    output fu_cdb_gnts,
    output cdb_ports
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of FU results onto NUM_CDB registered CDB ports (optional perf counters: CDB_ARBITER_PERF_EN).
// Grant is combinational in the request cycle; packet reaches the CDB one cycle later.
// No CDB backpressure; an ungranted FU simply keeps presenting its packet.

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int                 NUM_FU      = 5,
  parameter int                 NUM_CDB     = 2,
  parameter logic [NUM_FU-1:0]  FU_CDB_MASK = 5'b10111,
  localparam int                PTR_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  cdb_arbiter_if.slave      bus,
  output logic [PTR_W-1:0]  rr_ptr_o
`ifdef CDB_ARBITER_PERF_EN
  ,
  output logic [NUM_FU-1:0][31:0] perf_gnt_cnt,
  output logic [NUM_FU-1:0][31:0] perf_stall_cnt
`endif
);

  localparam int                CNT_W     = $clog2(NUM_CDB + 1);
  localparam logic [PTR_W:0]    NUM_FU_W  = (PTR_W + 1)'(NUM_FU);
  localparam logic [PTR_W-1:0]  LAST_FU   = PTR_W'(NUM_FU - 1);
  localparam logic [CNT_W-1:0]  NUM_CDB_W = CNT_W'(NUM_CDB);

  logic [NUM_FU-1:0]              req;
  logic [NUM_FU-1:0]              gnt_scan;
  logic [NUM_FU-1:0]              gnt;
  logic [NUM_CDB-1:0]             sel_vld;
  logic [NUM_CDB-1:0][PTR_W-1:0]  sel_idx;
  logic [PTR_W-1:0]               last_idx;
  logic                           arb_en;

  writeback_packet_t [NUM_CDB-1:0] cdb_d, cdb_q;
  logic [PTR_W-1:0]                rr_ptr_d, rr_ptr_q;

  // Flush and reset both silence the grant path.
  assign arb_en = rst_n & ~flush;

  // Request vector: valid results from FUs allowed to broadcast.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      req[i] = bus.fu_results[i].is_valid & FU_CDB_MASK[i];
    end
  end

  // Scan from rr_ptr upward with wrap, handing out ports in encounter order.
  always_comb begin
    logic [PTR_W:0]   idx;
    logic [CNT_W-1:0] cnt;
    gnt_scan = '0;
    sel_vld  = '0;
    sel_idx  = '0;
    last_idx = '0;
    cnt      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (idx >= NUM_FU_W) begin
        idx = idx - NUM_FU_W;
      end
      if (req[idx[PTR_W-1:0]] && (cnt < NUM_CDB_W)) begin
        gnt_scan[idx[PTR_W-1:0]] = 1'b1;
        sel_vld[cnt]             = 1'b1;
        sel_idx[cnt]             = idx[PTR_W-1:0];
        last_idx                 = idx[PTR_W-1:0];
        cnt                      = cnt + 1'b1;
      end
    end
  end

  assign gnt             = arb_en ? gnt_scan : '0;
  assign bus.fu_cdb_gnts = gnt;

  // Next CDB contents and pointer; unused ports go fully to zero.
  always_comb begin
    cdb_d = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (arb_en && sel_vld[k]) begin
        cdb_d[k] = bus.fu_results[sel_idx[k]];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (|gnt) begin
      rr_ptr_d = (last_idx == LAST_FU) ? '0 : last_idx + 1'b1;
    end
  end

  // CDB broadcast registers and rotating priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.cdb_ports = cdb_q;
  assign rr_ptr_o      = rr_ptr_q;

`ifdef CDB_ARBITER_PERF_EN
  logic [NUM_FU-1:0][31:0] perf_gnt_d,   perf_gnt_q;
  logic [NUM_FU-1:0][31:0] perf_stall_d, perf_stall_q;

  // Saturating per-FU grant and stall counts, frozen during flush.
  always_comb begin
    perf_gnt_d   = perf_gnt_q;
    perf_stall_d = perf_stall_q;
    if (arb_en) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (gnt[i] && (perf_gnt_q[i] != 32'hFFFF_FFFF)) begin
          perf_gnt_d[i] = perf_gnt_q[i] + 32'd1;
        end
        if (req[i] && !gnt[i] && (perf_stall_q[i] != 32'hFFFF_FFFF)) begin
          perf_stall_d[i] = perf_stall_q[i] + 32'd1;
        end
      end
    end
  end

  // Counter state; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_gnt_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_gnt_q   <= perf_gnt_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_gnt_cnt   = perf_gnt_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Arbitrates the execute-stage functional-unit result registers onto the common data bus (CDB) write-back ports. Each cycle it selects up to NUM_CDB valid FU results using a rotating (round-robin) priority and returns per-FU grants in the same cycle. Granted results are registered onto the CDB ports, so they appear on the CDB one cycle after the grant. It sits between the execute unit's fu_results/fu_cdb_gnts interface and the CDB consumers: ROB, reservation stations and the PRF write ports.

Parameters:
NUM_FU, 5, number of FU result requesters (indices match execute: 0/1 ALU, 2 MEM, 3 AGU, 4 MDU)
NUM_CDB, 2, number of CDB broadcast ports
FU_CDB_MASK, 5'b10111, bit i=1 means FU i may write the CDB; AGU (bit 3) is excluded

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous assert, active-low
flush  input  1  pipeline flush; synchronous, active-high
fu_results  input  writeback_packet_t[NUM_FU]  held FU output packets; request = is_valid
fu_cdb_gnts  output  logic[NUM_FU]  combinational grant; the FU advances its output register on grant
cdb_ports  output  writeback_packet_t[NUM_CDB]  registered CDB broadcast packets
rr_ptr_o  output  $clog2(NUM_FU)  current highest-priority FU index (debug/verification visibility)

Behaviour:
- Request vector: req[i] = fu_results[i].is_valid & FU_CDB_MASK[i]. Masked FUs are never granted, even if valid.
- Selection:
  - Scan FU indices starting at rr_ptr, ascending, wrapping modulo NUM_FU.
  - Grant the first min(popcount(req), NUM_CDB) requesters encountered.
- Grant timing:
  - fu_cdb_gnts is combinational in the same cycle as req.
  - gnt[i] is 1 only if req[i] is 1.
  - At most NUM_CDB grants are asserted in any cycle.
- Port ordering: the k-th granted FU in scan order maps to cdb_ports[k]. Unused ports carry is_valid=0 and all other fields 0.
- CDB register:
  - At the clock edge, cdb_ports[k] <= the packet of the k-th granted FU, with is_valid=1.
  - Latency from grant to CDB is exactly 1 cycle.
  - The packet is a bit-exact copy of the granted fu_results entry.
- Pointer update:
  - If any grant occurs, rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
  - If there are no grants, rr_ptr holds.
- Fairness: a continuously valid, unmasked FU is granted within ceil(NUM_FU/NUM_CDB) cycles of first asserting is_valid.
- Flush:
  - While flush=1, all grants are forced to 0.
  - cdb_ports clear to invalid at the next edge.
  - rr_ptr <= 0.
  - Flush has priority over any simultaneous request.
- Reset:
  - When rst_n=0, immediately and asynchronously: all cdb_ports invalid/zero, rr_ptr=0.
  - While rst_n=0, fu_cdb_gnts=0.
  - Normal operation resumes on the first edge after deassertion.
- Boundaries:
  - popcount(req) <= NUM_CDB: every requester is granted.
  - popcount(req) = 0: no grants, CDB invalid next cycle, rr_ptr holds.
  - rr_ptr pointing at a masked or idle FU: the scan simply continues past it.
  - Wrap-around: the scan proceeds ..., NUM_FU-1, 0, ...
- There is no backpressure from the CDB: registered ports are overwritten every cycle.

Optional Feature:
Macro CDB_ARBITER_PERF_EN.
- Defined:
  - Adds output perf_gnt_cnt (32b x NUM_FU): per-FU grant counts.
  - Adds output perf_stall_cnt (32b x NUM_FU): per-FU count of cycles with req=1 and gnt=0.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both are cleared by rst_n. They are not cleared by flush.
  - Counting is suppressed while flush=1.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
1. rst_n pulsed low mid-cycle while FU0 is valid -> cdb_ports[*].is_valid=0 immediately, rr_ptr_o=0, fu_cdb_gnts=0 during reset.
2. rr_ptr=0; FU0, FU1, FU2 and FU4 held valid continuously (each re-presents a new packet after grant) ->
   - cycle 0: gnts=5'b00011; rr_ptr becomes 2
   - cycle 1: cdb_ports={FU0,FU1} pkts; gnts=5'b10100; rr_ptr becomes 0
   - cycle 2: cdb_ports={FU2,FU4} pkts
3. Only FU4 valid with rr_ptr=1 -> gnts=5'b10000; next cycle cdb_ports[0]=FU4 pkt, cdb_ports[1].is_valid=0; rr_ptr=0 (wrap).
4. FU3 (AGU) is_valid=1 alone for 3 cycles -> gnts=0 every cycle, CDB invalid, rr_ptr unchanged.
5. flush=1 while FU0 and FU2 are valid -> gnts=0; next edge cdb_ports invalid, rr_ptr=0; after flush=0, FU0 is granted first.
6. With CDB_ARBITER_PERF_EN: 3 requesters valid for 1 cycle with NUM_CDB=2 -> perf_gnt_cnt increments for the 2 granted FUs and perf_stall_cnt[loser]=1; a counter preloaded at 32'hFFFF_FFFF stays at 32'hFFFF_FFFF on a further grant.
